// File: rtl/complete_stage_arb.sv
// rtl/complete_stage_arb.sv - FU completion arbiter with in-order queue feeding the CDB

package complete_stage_pkg;
    typedef struct packed {
        logic        halt;
        logic        take_branch;
        logic [31:0] target_pc;
        logic [31:0] dest_value;
        logic [5:0]  pr_idx;
        logic [4:0]  rob_idx;
    } fu_complete_packet_t;
endpackage

module complete_stage_arb
    import complete_stage_pkg::*;
#(
    parameter int NUM_FU    = 4,
    parameter int CDB_WIDTH = 2,
    parameter int BUF_DEPTH = 4
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  squash,
    input  logic [NUM_FU-1:0]                     fu_want_to_complete,
    input  fu_complete_packet_t [NUM_FU-1:0]      fu_packet_in,
    output logic [NUM_FU-1:0]                     complete_stall,
    output logic [CDB_WIDTH-1:0]                  cdb_valid,
    output fu_complete_packet_t [CDB_WIDTH-1:0]   cdb_packet_out
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int FW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int GW = $clog2(NUM_FU + 1);

    fu_complete_packet_t mem [BUF_DEPTH];
    logic [PW-1:0]       head;
    logic [PW-1:0]       tail;
    logic [CW-1:0]       count;
    logic [FW-1:0]       rr_ptr;

    logic [CW-1:0]       deq;
    logic [CW-1:0]       free;
    logic [NUM_FU-1:0]   grant;
    logic [PW-1:0]       slot_of [NUM_FU];
    logic [GW-1:0]       n_grant;
    logic [FW-1:0]       last_fu;

    // The CDB never stalls, so up to CDB_WIDTH entries leave every cycle and their space is reusable now
    always_comb begin
        if (count > CW'(CDB_WIDTH)) begin
            deq = CW'(CDB_WIDTH);
        end else begin
            deq = count;
        end
        free = CW'(BUF_DEPTH) - count + deq;
    end

    // Round-robin scan from rr_ptr granting the first `free` requesters; each grant gets a tail offset
    always_comb begin
        logic [FW-1:0] idx;
        grant   = '0;
        n_grant = '0;
        last_fu = rr_ptr;
        idx     = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            slot_of[f] = '0;
        end
        if (!squash) begin
            for (int i = 0; i < NUM_FU; i++) begin
                idx = FW'((int'(rr_ptr) + i) % NUM_FU);
                if (fu_want_to_complete[idx] && (int'(n_grant) < int'(free))) begin
                    grant[idx]   = 1'b1;
                    slot_of[idx] = PW'(n_grant);
                    n_grant      = n_grant + GW'(1);
                    last_fu      = idx;
                end
            end
        end
    end

    // Stall every FU during reset; on squash nobody stalls because the FUs discard their packets
    always_comb begin
        if (reset) begin
            complete_stall = '1;
        end else if (squash) begin
            complete_stall = '0;
        end else begin
            complete_stall = fu_want_to_complete & ~grant;
        end
    end

    // Broadcast the oldest entries, slot 0 = head; unused slots carry an all-zero packet
    always_comb begin
        for (int k = 0; k < CDB_WIDTH; k++) begin
            if (CW'(k) < deq) begin
                cdb_valid[k]      = 1'b1;
                cdb_packet_out[k] = mem[head + PW'(k)];
            end else begin
                cdb_valid[k]      = 1'b0;
                cdb_packet_out[k] = '0;
            end
        end
    end

    // Queue pointers, occupancy and round-robin pointer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            rr_ptr <= '0;
        end else if (squash) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
        end else begin
            count <= count - deq + CW'(n_grant);
            head  <= head + PW'(deq);
            tail  <= tail + PW'(n_grant);
            if (n_grant != '0) begin
                rr_ptr <= FW'((int'(last_fu) + 1) % NUM_FU);
            end
        end
    end

    // Packet storage; granted packets land at tail in scan order
    always_ff @(posedge clock) begin
        for (int f = 0; f < NUM_FU; f++) begin
            if (grant[f]) begin
                mem[tail + slot_of[f]] <= fu_packet_in[f];
            end
        end
    end

endmodule

// File: tb/tb_complete_stage_arb.sv
// tb/tb_complete_stage_arb.sv - self-checking bench for complete_stage_arb

module tb_complete_stage_arb;
    import complete_stage_pkg::*;

    logic                          clock = 1'b0;
    logic                          reset = 1'b1;
    logic                          squash = 1'b0;
    logic [3:0]                    req = '0;
    fu_complete_packet_t [3:0]     pkt_in;
    logic [3:0]                    complete_stall;
    logic [1:0]                    cdb_valid;
    fu_complete_packet_t [1:0]     cdb_packet_out;

    complete_stage_arb #(.NUM_FU(4), .CDB_WIDTH(2), .BUF_DEPTH(4)) dut (
        .clock               (clock),
        .reset               (reset),
        .squash              (squash),
        .fu_want_to_complete (req),
        .fu_packet_in        (pkt_in),
        .complete_stall      (complete_stall),
        .cdb_valid           (cdb_valid),
        .cdb_packet_out      (cdb_packet_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] req;
        logic       sq;
        logic [3:0] stall;
        logic [1:0] valid;
    } vec_t;

    fu_complete_packet_t exp_q[$];
    fu_complete_packet_t fu_pkt[4];
    logic [4:0]          obs[$];
    int                  rr_m;
    int                  n_tests;
    int                  n_fail;
    int                  tag;
    bit                  collect;
    logic [3:0]          last_grant;

    function automatic fu_complete_packet_t mk(input int t);
        fu_complete_packet_t p;
        p             = '0;
        p.rob_idx     = t[4:0];
        p.pr_idx      = 6'($urandom);
        p.dest_value  = $urandom;
        p.target_pc   = $urandom;
        p.take_branch = 1'($urandom);
        p.halt        = 1'($urandom);
        return p;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, compare combinational outputs, update scoreboard, cross the edge
    task automatic step(input logic [3:0] r, input logic sq,
                        output logic [3:0] a_stall, output logic [1:0] a_valid);
        int         nd;
        int         fr;
        int         cnt;
        int         last;
        int         f;
        int         ord[$];
        logic [3:0] g;
        logic [3:0] m_stall;
        req    = r;
        squash = sq;
        for (int i = 0; i < 4; i++) pkt_in[i] = fu_pkt[i];
        #1;
        a_stall = complete_stall;
        a_valid = cdb_valid;
        nd = (exp_q.size() > 2) ? 2 : exp_q.size();
        for (int k = 0; k < 2; k++) begin
            check("cdb_valid", 128'(cdb_valid[k]), 128'(k < nd));
            if (k < nd) check("cdb_packet", 128'(cdb_packet_out[k]), 128'(exp_q[k]));
            if (collect && cdb_valid[k]) obs.push_back(cdb_packet_out[k].rob_idx);
        end
        g = '0; cnt = 0; last = 0;
        if (!sq) begin
            fr = 4 - exp_q.size() + nd;
            for (int i = 0; i < 4; i++) begin
                f = (rr_m + i) % 4;
                if (r[f] && cnt < fr) begin
                    g[f] = 1'b1;
                    ord.push_back(f);
                    cnt++;
                    last = f;
                end
            end
        end
        m_stall = sq ? 4'b0000 : (r & ~g);
        check("complete_stall", 128'(complete_stall), 128'(m_stall));
        repeat (nd) void'(exp_q.pop_front());
        if (sq) exp_q.delete();
        else foreach (ord[i]) exp_q.push_back(fu_pkt[ord[i]]);
        if (cnt > 0) rr_m = (last + 1) % 4;
        for (int i = 0; i < 4; i++) begin
            if (r[i] && (g[i] || sq)) begin
                fu_pkt[i] = mk(tag);
                tag++;
            end
        end
        last_grant = g;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       vecs[17];
        logic [3:0] a_s;
        logic [1:0] a_v;
        int         sent;
        int         guard;
        n_tests = 0; n_fail = 0; tag = 20; rr_m = 0; collect = 0;
        for (int i = 0; i < 4; i++) begin
            fu_pkt[i] = mk(tag);
            tag++;
            pkt_in[i] = fu_pkt[i];
        end

        // two-FU drain, continuous contention, then squash
        vecs[0]  = '{4'b1111, 1'b0, 4'b0000, 2'b00};
        vecs[1]  = '{4'b0000, 1'b0, 4'b0000, 2'b11};
        vecs[2]  = '{4'b0000, 1'b0, 4'b0000, 2'b11};
        vecs[3]  = '{4'b0000, 1'b0, 4'b0000, 2'b00};
        vecs[4]  = '{4'b1111, 1'b0, 4'b0000, 2'b00};
        vecs[5]  = '{4'b1111, 1'b0, 4'b1100, 2'b11};
        vecs[6]  = '{4'b1111, 1'b0, 4'b0011, 2'b11};
        vecs[7]  = '{4'b0000, 1'b0, 4'b0000, 2'b11};
        vecs[8]  = '{4'b0000, 1'b0, 4'b0000, 2'b11};
        vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 2'b00};
        vecs[10] = '{4'b1111, 1'b0, 4'b0000, 2'b00};
        vecs[11] = '{4'b0001, 1'b0, 4'b0000, 2'b11};
        vecs[12] = '{4'b0011, 1'b1, 4'b0000, 2'b11};
        vecs[13] = '{4'b0000, 1'b0, 4'b0000, 2'b00};
        vecs[14] = '{4'b0100, 1'b0, 4'b0000, 2'b00};
        vecs[15] = '{4'b0000, 1'b0, 4'b0000, 2'b01};
        vecs[16] = '{4'b0000, 1'b0, 4'b0000, 2'b00};

        #2;
        check("reset_stall", 128'(complete_stall), 128'(4'b1111));
        check("reset_valid", 128'(cdb_valid), 128'(2'b00));
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].req, vecs[i].sq, a_s, a_v);
            check($sformatf("vec%0d_stall", i), 128'(a_s), 128'(vecs[i].stall));
            check($sformatf("vec%0d_valid", i), 128'(a_v), 128'(vecs[i].valid));
        end

        // single FU1 packet, one-cycle latency with exact field values
        fu_pkt[1] = mk(5);
        fu_pkt[1].dest_value = 32'h1234;
        step(4'b0010, 1'b0, a_s, a_v);
        check("t1_stall", 128'(a_s), 128'(4'b0000));
        #1;
        check("t1_valid", 128'(cdb_valid), 128'(2'b01));
        check("t1_rob", 128'(cdb_packet_out[0].rob_idx), 128'(5'd5));
        check("t1_dest", 128'(cdb_packet_out[0].dest_value), 128'(32'h1234));
        step(4'b0000, 1'b0, a_s, a_v);
        step(4'b0000, 1'b0, a_s, a_v);
        check("t1_empty", 128'(a_v), 128'(2'b00));

        for (int i = 10; i < 17; i++) begin
            step(vecs[i].req, vecs[i].sq, a_s, a_v);
            check($sformatf("vec%0d_stall", i), 128'(a_s), 128'(vecs[i].stall));
            check($sformatf("vec%0d_valid", i), 128'(a_v), 128'(vecs[i].valid));
        end

        // reset dropped on the queue between edges with three entries held
        step(4'b1111, 1'b0, a_s, a_v);
        step(4'b0001, 1'b0, a_s, a_v);
        check("t5_pre_count", 128'(exp_q.size()), 128'(3));
        req = 4'b1111;
        #2;
        reset = 1'b1;
        #1;
        check("t5_valid_now", 128'(cdb_valid), 128'(2'b00));
        check("t5_stall_now", 128'(complete_stall), 128'(4'b1111));
        @(posedge clock);
        @(negedge clock);
        #1;
        check("t5_stall_held", 128'(complete_stall), 128'(4'b1111));
        check("t5_valid_held", 128'(cdb_valid), 128'(2'b00));
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        rr_m = 0;
        step(4'b0100, 1'b0, a_s, a_v);
        check("t5_post_stall", 128'(a_s), 128'(4'b0000));
        step(4'b0000, 1'b0, a_s, a_v);
        check("t5_post_valid", 128'(a_v), 128'(2'b01));

        // ten packets from FU2 with random gaps, wrapping the queue
        collect = 1;
        obs.delete();
        sent = 0;
        guard = 0;
        while (sent < 10 && guard < 200) begin
            if ($urandom_range(0, 2) == 0) begin
                step(4'b0000, 1'b0, a_s, a_v);
            end else begin
                fu_pkt[2].rob_idx = sent[4:0];
                step(4'b0100, 1'b0, a_s, a_v);
                if (last_grant[2]) sent++;
            end
            guard++;
        end
        check("t6_sent", 128'(sent), 128'(10));
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            step(4'b0000, 1'b0, a_s, a_v);
            guard++;
        end
        collect = 0;
        check("t6_drained", 128'(exp_q.size()), 128'(0));
        check("t6_count", 128'(obs.size()), 128'(10));
        for (int i = 0; i < obs.size() && i < 10; i++) begin
            check($sformatf("t6_order%0d", i), 128'(obs[i]), 128'(i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
